// File: rtl/reg_dump_reader.sv
// reg_dump_reader: reads a contiguous range of register-file entries through a single read port.
// Each captured 32-bit word is streamed out little-endian as bytes on a valid/ready interface.
// Optional build macro REG_DUMP_HEADER_EN: when defined, each word is preceded by a header byte {3'b000, addr}.
module reg_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef REG_DUMP_HEADER_EN
        S_HDR,
`endif
        S_SEND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q,  addr_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q,   cnt_d;

    // State register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: word address, captured word, byte counter
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            addr_q  <= FIRST_ADDR;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = FIRST_ADDR;
                end
            end
            S_LOAD: begin
                shift_d = rd_data;
                cnt_d   = '0;
`ifdef REG_DUMP_HEADER_EN
                state_d = S_HDR;
`else
                state_d = S_SEND;
`endif
            end
`ifdef REG_DUMP_HEADER_EN
            S_HDR: begin
                if (tx_ready) begin
                    state_d = S_SEND;
                end
            end
`endif
            S_SEND: begin
                if (tx_ready) begin
                    shift_d = {8'h00, shift_q[31:8]};
                    cnt_d   = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = 5'(addr_q + 5'd1);
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        rd_addr  = addr_q;
        tx_data  = '0;
        tx_valid = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        unique case (state_q)
`ifdef REG_DUMP_HEADER_EN
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = {3'b000, addr_q};
            end
`endif
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: three instances (full range, single register, two registers)
// share a register-file model; the expected byte streams are built from that model.
module tb_reg_dump_reader;

`ifdef REG_DUMP_HEADER_EN
    localparam int unsigned HDR = 1;
`else
    localparam int unsigned HDR = 0;
`endif
    localparam int unsigned BPR = 4 + HDR;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [2:0]       start;
    logic [2:0]       tx_ready;
    logic [2:0]       tx_valid;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0][4:0]  rd_addr;
    logic [2:0][31:0] rd_data;
    logic [2:0][7:0]  tx_data;

    logic [31:0] regs [32];
    logic [7:0]  got_q [$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < 3; g++) begin : g_rf
        assign rd_data[g] = (rd_addr[g] == 5'd0) ? 32'h0 : regs[rd_addr[g]];
    end

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk_in(clk_in), .reset(reset), .start(start[0]),
        .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) u_one (
        .clk_in(clk_in), .reset(reset), .start(start[1]),
        .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    reg_dump_reader #(.FIRST_REG(1), .LAST_REG(2)) u_pair (
        .clk_in(clk_in), .reset(reset), .start(start[2]),
        .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
        .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .busy(busy[2]), .done(done[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: ready low for 100 valid cycles, then high.
    // repulse: pulse start mid-dump and on the DONE cycle; both must be ignored.
    task automatic run_dump(input int unsigned k, input int unsigned first, input int unsigned last,
                            input int unsigned mode, input bit repulse);
        logic [7:0]  exp_q [$];
        int unsigned nbytes = 0, ndone = 0, cyc = 0, stall = 0, post = 0, last_hs = 0;
        logic        pv = 1'b0, pr = 1'b0;
        logic [7:0]  pd = 8'h00;
        logic [31:0] w;
        for (int unsigned r = first; r <= last; r++) begin
            w = regs[r];
            if (HDR != 0) exp_q.push_back(8'(r));
            for (int unsigned b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
        got_q.delete();

        @(negedge clk_in);
        start[k]    = 1'b1;
        tx_ready[k] = (mode != 2);
        @(negedge clk_in);
        start[k] = 1'b0;
        #1;
        check_eq("load_busy", 32'(busy[k]), 32'd1);
        check_eq("load_valid", 32'(tx_valid[k]), 32'd0);
        check_eq("load_addr", 32'(rd_addr[k]), first);

        while (cyc < 3000) begin
            @(negedge clk_in);
            case (mode)
                0:       tx_ready[k] = 1'b1;
                1:       tx_ready[k] = (cyc % 3 == 0);
                default: tx_ready[k] = (stall >= 100);
            endcase
            start[k] = repulse && ((cyc == 40) || (nbytes == exp_q.size() && ndone == 0));
            #1;
            if (cyc == 0) check_eq("first_valid", 32'(tx_valid[k]), 32'd1);
            if (pv && !pr) begin
                check_eq("stall_valid", 32'(tx_valid[k]), 32'd1);
                check_eq("stall_data", 32'(tx_data[k]), 32'(pd));
            end
            if (mode == 2 && stall == 50) begin
                check_eq("stall_addr", 32'(rd_addr[k]), first);
                check_eq("stall_byte", 32'(tx_data[k]), 32'(exp_q[0]));
            end
            if (tx_valid[k] && !tx_ready[k]) stall++;
            if (tx_valid[k] && tx_ready[k]) begin
                if (nbytes < exp_q.size())
                    check_eq($sformatf("byte%0d", nbytes), 32'(tx_data[k]), 32'(exp_q[nbytes]));
                got_q.push_back(tx_data[k]);
                nbytes++;
                last_hs = cyc;
            end
            if (done[k]) begin
                ndone++;
                check_eq("done_timing", cyc, last_hs + 1);
            end
            pv = tx_valid[k];
            pr = tx_ready[k];
            pd = tx_data[k];
            cyc++;
            if (ndone != 0) begin
                post++;
                if (post >= 20) break;
            end
        end
        start[k] = 1'b0;
        check_eq("byte_count", nbytes, exp_q.size());
        check_eq("done_count", ndone, 32'd1);
        check_eq("busy_after", 32'(busy[k]), 32'd0);
        check_eq("valid_after", 32'(tx_valid[k]), 32'd0);
    endtask

    initial begin
        int unsigned n, nd, cyc, pos;
        for (int i = 0; i < 32; i++) regs[i] = {8'(i), 8'hC3, 8'(i * 3), 8'h5A};
        regs[0] = 32'h0;
        regs[1] = 32'h0;
        regs[2] = 32'h00001000;
        regs[5] = 32'hDEADBEEF;

        reset    = 1'b1;
        start    = '0;
        tx_ready = '0;
        repeat (3) @(negedge clk_in);
        #1;
        check_eq("rst_addr0", 32'(rd_addr[0]), 32'd0);
        check_eq("rst_addr1", 32'(rd_addr[1]), 32'd5);
        check_eq("rst_data", 32'(tx_data[0]), 32'd0);
        check_eq("rst_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Full default dump with ignored start re-pulses
        run_dump(0, 0, 31, 0, 1'b1);
        check_eq("x0_word", {got_q[HDR + 3], got_q[HDR + 2], got_q[HDR + 1], got_q[HDR]}, 32'h0);
        pos = 2 * BPR + HDR;
        check_eq("x2_word", {got_q[pos + 3], got_q[pos + 2], got_q[pos + 1], got_q[pos]}, 32'h00001000);

        // Single register with stalling sink
        run_dump(1, 5, 5, 1, 1'b0);
        check_eq("x5_word", {got_q[HDR + 3], got_q[HDR + 2], got_q[HDR + 1], got_q[HDR]}, 32'hDEADBEEF);
        if (HDR != 0) check_eq("x5_hdr", 32'(got_q[0]), 32'h05);

        // Two-register range
        run_dump(2, 1, 2, 0, 1'b0);
        check_eq("pair_len", got_q.size(), 2 * BPR);

        // Reset while byte 2 of x7 is presented
        pos = 7 * BPR + HDR + 2;
        n   = 0;
        nd  = 0;
        cyc = 0;
        tx_ready[0] = 1'b1;
        @(negedge clk_in);
        start[0] = 1'b1;
        @(negedge clk_in);
        start[0] = 1'b0;
        while (n < pos && cyc < 500) begin
            @(negedge clk_in);
            #1;
            if (tx_valid[0] && tx_ready[0]) n++;
            if (done[0]) nd++;
            cyc++;
        end
        @(negedge clk_in);
        #1;
        check_eq("mid_addr", 32'(rd_addr[0]), 32'd7);
        check_eq("mid_byte", 32'(tx_data[0]), 32'(regs[7][23:16]));
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(tx_valid[0]), 32'd0);
        check_eq("arst_busy", 32'(busy[0]), 32'd0);
        check_eq("arst_addr", 32'(rd_addr[0]), 32'd0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            #1;
            if (done[0]) nd++;
            if (tx_valid[0]) nd++;
        end
        check_eq("no_done_after_rst", nd, 32'd0);

        // Restart from FIRST_REG after the abandoned dump
        run_dump(0, 0, 31, 0, 1'b0);

        // Long sink stall right after the first valid byte
        run_dump(0, 0, 31, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
